// File: rtl/thermal_line_fetch.sv
// thermal_line_fetch: prefetches one thermal-sensor source row per scaled
// output row into a ping-pong line buffer, replicates every source pixel
// p_scale times on both axes, and shares the single frame-buffer port between
// display fetches (priority) and the sensor writer.
// Build option: define UNDERRUN_STICKY_EN to latch o_underrun until reset;
// otherwise o_underrun is a one-cycle pulse.
module thermal_line_fetch #(
  parameter int p_src_width   = 32,
  parameter int p_src_height  = 24,
  parameter int p_scale       = 20,
  parameter int p_data_width  = 16,
  parameter int p_addr_width  = 10,
  parameter int p_count_width = 16
) (
  input  logic                            i_clk_pixel,
  input  logic                            i_rst,
  input  logic                            i_line,
  input  logic                            i_data_en,
  input  logic signed [p_count_width-1:0] i_y_pos,
  input  logic                            i_wr_valid,
  output logic                            o_wr_ready,
  input  logic [p_addr_width-1:0]         i_wr_addr,
  input  logic [p_data_width-1:0]         i_wr_data,
  output logic                            o_mem_en,
  output logic                            o_mem_we,
  output logic [p_addr_width-1:0]         o_mem_addr,
  output logic [p_data_width-1:0]         o_mem_wdata,
  input  logic [p_data_width-1:0]         i_mem_rdata,
  output logic [p_data_width-1:0]         o_pixel,
  output logic                            o_pixel_valid,
  output logic                            o_underrun
);

  localparam int KW = $clog2(p_src_width + 1);
  localparam int IW = (p_src_width > 1) ? $clog2(p_src_width) : 1;
  localparam int SW = (p_scale > 1) ? $clog2(p_scale) : 1;
  localparam int NW = $clog2(p_src_height + 1);

  localparam logic signed [p_count_width-1:0] Y_PRE       = '1;
  localparam logic signed [p_count_width-1:0] Y_FETCH_END =
    p_count_width'(p_src_height * p_scale - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [NW-1:0]           row_q, row_d;
  logic                    fetch_bank_q, fetch_bank_d;
  logic                    disp_bank_q, disp_bank_d;
  logic                    swap_pending_q, swap_pending_d;
  logic [NW-1:0]           next_row_q, next_row_d;
  logic [SW-1:0]           rep_cnt_q, rep_cnt_d;
  logic [KW-1:0]           col_q, col_d;
  logic [SW-1:0]           sub_cnt_q, sub_cnt_d;
  logic [p_data_width-1:0] pixel_q, pixel_d;
  logic                    pixel_valid_q, pixel_valid_d;
  logic                    underrun_q, underrun_d;

  logic [p_data_width-1:0] linebuf_q [0:1][0:p_src_width-1];

  logic                    fetch_req;
  logic [NW-1:0]           fetch_row;
  logic                    underrun_evt;
  logic                    lb_we;
  logic [IW-1:0]           lb_idx;
  logic [p_addr_width-1:0] fetch_addr;

  assign fetch_addr = p_addr_width'(row_q) * p_addr_width'(p_src_width)
                    + p_addr_width'(k_q);
  assign o_wr_ready = !i_rst && (state_q == ST_IDLE) && !i_line;

  // Vertical sequencing: bank swap, row selection and replication count on each line strobe.
  always_comb begin
    disp_bank_d    = disp_bank_q;
    swap_pending_d = swap_pending_q;
    next_row_d     = next_row_q;
    rep_cnt_d      = rep_cnt_q;
    fetch_req      = 1'b0;
    fetch_row      = '0;
    underrun_evt   = 1'b0;
    if (i_line) begin
      if (swap_pending_q) begin
        disp_bank_d    = ~disp_bank_q;
        swap_pending_d = 1'b0;
        underrun_evt   = (state_q != ST_IDLE);
      end
      if (i_y_pos == Y_PRE) begin
        fetch_req  = 1'b1;
        fetch_row  = '0;
        next_row_d = NW'(1);
        rep_cnt_d  = '0;
      end else if (!i_y_pos[p_count_width-1] && (i_y_pos < Y_FETCH_END)) begin
        if (rep_cnt_q == SW'(p_scale - 1)) begin
          rep_cnt_d = '0;
          if (next_row_q < NW'(p_src_height)) begin
            fetch_req  = 1'b1;
            fetch_row  = next_row_q;
            next_row_d = next_row_q + NW'(1);
          end
        end else begin
          rep_cnt_d = rep_cnt_q + SW'(1);
        end
      end
      if (fetch_req) swap_pending_d = 1'b1;
    end
  end

  // Fetch FSM: read one row word per cycle, store each word one cycle later.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    row_d        = row_q;
    fetch_bank_d = fetch_bank_q;
    lb_we        = 1'b0;
    lb_idx       = IW'(k_q - KW'(1));
    unique case (state_q)
      ST_FETCH: begin
        lb_we = (k_q != '0);
        k_d   = k_q + KW'(1);
        if (k_q == KW'(p_src_width - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        lb_we   = 1'b1;
        state_d = ST_IDLE;
      end
      default: ;
    endcase
    // Target bank is latched at request time so a late swap lets the fetch
    // finish into the bank it started on.
    if (fetch_req) begin
      state_d      = ST_FETCH;
      k_d          = '0;
      row_d        = fetch_row;
      fetch_bank_d = ~disp_bank_d;
    end
  end

  // Memory port: fetch reads win; writer only gets the port while ready.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (!i_rst && (state_q == ST_FETCH)) begin
      o_mem_en   = 1'b1;
      o_mem_addr = fetch_addr;
    end else if (i_wr_valid && o_wr_ready) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = i_wr_addr;
      o_mem_wdata = i_wr_data;
    end
  end

  // Horizontal replication: each buffered pixel is repeated p_scale times.
  always_comb begin
    col_d         = col_q;
    sub_cnt_d     = sub_cnt_q;
    pixel_d       = pixel_q;
    pixel_valid_d = i_data_en;
    if (i_data_en) begin
      pixel_d = (col_q < KW'(p_src_width)) ? linebuf_q[disp_bank_q][IW'(col_q)] : '0;
    end
    if (i_line) begin
      col_d     = '0;
      sub_cnt_d = '0;
    end else if (i_data_en) begin
      if (sub_cnt_q == SW'(p_scale - 1)) begin
        sub_cnt_d = '0;
        if (col_q != KW'(p_src_width)) col_d = col_q + KW'(1);
      end else begin
        sub_cnt_d = sub_cnt_q + SW'(1);
      end
    end
`ifdef UNDERRUN_STICKY_EN
    underrun_d = underrun_q | underrun_evt;
`else
    underrun_d = underrun_evt;
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      row_q          <= '0;
      fetch_bank_q   <= 1'b0;
      disp_bank_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      next_row_q     <= '0;
      rep_cnt_q      <= '0;
      col_q          <= '0;
      sub_cnt_q      <= '0;
      pixel_q        <= '0;
      pixel_valid_q  <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      row_q          <= row_d;
      fetch_bank_q   <= fetch_bank_d;
      disp_bank_q    <= disp_bank_d;
      swap_pending_q <= swap_pending_d;
      next_row_q     <= next_row_d;
      rep_cnt_q      <= rep_cnt_d;
      col_q          <= col_d;
      sub_cnt_q      <= sub_cnt_d;
      pixel_q        <= pixel_d;
      pixel_valid_q  <= pixel_valid_d;
      underrun_q     <= underrun_d;
    end
  end

  // Line buffer write port: contents are not reset.
  always_ff @(posedge i_clk_pixel) begin
    if (lb_we && !i_rst) linebuf_q[fetch_bank_q][lb_idx] <= i_mem_rdata;
  end

  assign o_pixel       = pixel_q;
  assign o_pixel_valid = pixel_valid_q;
  assign o_underrun    = underrun_q;

endmodule

// File: doc/thermal_line_fetch.md
# thermal_line_fetch

Sequences frame-buffer reads for the pixel pipeline. It watches the line/frame strobes and pixel counters from the VGA timing generator and prefetches one thermal-sensor source row per scaled output row into a ping-pong line buffer. It replicates each source pixel horizontally and vertically by an integer scale. It also arbitrates the single frame-buffer memory port between display fetches, which have priority, and the sensor writer.

## Interface
- p_src_width, 32, source pixels per row
- p_src_height, 24, source rows
- p_scale, 20, integer upscale factor applied on both axes
- p_data_width, 16, pixel width
- p_addr_width, 10, frame-buffer address width; must satisfy 2^p_addr_width ≥ p_src_width*p_src_height
- p_count_width, 16, width of signed timing counters

Ports:
- i_clk_pixel  in  1  pixel clock
- i_rst  in  1  reset, synchronous, active-high
- i_line  in  1  one-cycle strobe, 10 cycles before x=0 of every line
- i_data_en  in  1  visible-pixel enable from the timing generator
- i_y_pos  in  p_count_width signed  current line; negative during vertical blanking
- i_wr_valid  in  1  sensor writer request
- o_wr_ready  out  1  writer granted this cycle
- i_wr_addr  in  p_addr_width  writer address
- i_wr_data  in  p_data_width  writer data
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  write when 1, read when 0
- o_mem_addr  out  p_addr_width  memory address
- o_mem_wdata  out  p_data_width  write data
- i_mem_rdata  in  p_data_width  read data, valid one cycle after a read
- o_pixel  out  p_data_width  scaled pixel
- o_pixel_valid  out  1  i_data_en delayed by one cycle
- o_underrun  out  1  a fetch was still busy at a bank swap

## Operation
- Line buffer: 2 banks × p_src_width entries. disp_bank selects the bank being displayed; fetches write to bank ~disp_bank.
- Fetch FSM states:
  - IDLE: waits for a fetch request, then moves to FETCH.
  - FETCH: issues reads for k = 0..p_src_width-1, one per cycle, at o_mem_addr = row*p_src_width + k; each i_mem_rdata is stored at entry k-1 on the following cycle.
  - DRAIN: one cycle that stores the last word, then returns to IDLE. A fetch occupies the FSM for p_src_width+1 cycles.
- Vertical sequencing, evaluated on each i_line:
  1. If swap_pending is set: toggle disp_bank and clear swap_pending. If the FSM is not IDLE, pulse o_underrun; the swap happens regardless and the in-flight fetch completes into the now-displayed bank.
  2. If i_y_pos == -1: request a fetch of row 0, then set next_row=1 and rep_cnt=0.
  3. Else if 0 ≤ i_y_pos < p_src_height*p_scale-1:
     - If rep_cnt == p_scale-1: clear rep_cnt; if next_row < p_src_height, fetch next_row and increment next_row.
     - Otherwise increment rep_cnt.
  4. Any requested fetch sets swap_pending. Other lines do nothing.
- Horizontal replication:
  - col and sub_cnt clear on i_line.
  - On each i_data_en cycle, o_pixel <= linebuf[disp_bank][col], or 0 if col ≥ p_src_width.
  - sub_cnt counts to p_scale-1, then wraps and increments col; col saturates at p_src_width.
- Arbitration:
  - o_wr_ready = !i_rst && FSM==IDLE && !i_line.
  - On a handshake (i_wr_valid && o_wr_ready): o_mem_en=1, o_mem_we=1, and addr/data are passed through in the same cycle.
  - A fetch issue drives o_mem_we=0. There is no collision by construction.
- Row arithmetic: row*p_src_width is computed with p_addr_width bits and never wraps for legal parameters.

## Timing
- Reset: all registered outputs are 0; disp_bank=0, swap_pending=0, FSM=IDLE, next_row=0, rep_cnt=0, col=0, sub_cnt=0; o_wr_ready=0 while i_rst.
- Reset mid-fetch: the fetch is aborted immediately with no further memory strobes; the line buffer contents are don't-care.
- Memory strobes (o_mem_en/we/addr/wdata) are combinational from state and the writer inputs. The first fetch read is issued the cycle after i_line.
- Pixel latency: o_pixel/o_pixel_valid lag i_data_en by exactly 1 cycle.
- Simultaneous i_line and i_wr_valid: the writer is stalled (ready=0) and the fetch starts next cycle.

## Configuration
- UNDERRUN_STICKY_EN defined: o_underrun sets on an underrun and stays 1 until i_rst.
- UNDERRUN_STICKY_EN undefined: o_underrun is a one-cycle pulse in the cycle after the offending i_line.

## Test plan
- Default params, 640×480 timing, frame buffer holding addr value: output line y, pixel x equals (y/20)*32 + x/20 for all visible pixels; o_underrun never asserts.
- i_line with i_y_pos=-1: read addresses 0..31 on consecutive cycles starting 1 cycle later; o_wr_ready=0 for 33 cycles, then 1.
- Constant i_wr_valid across a frame: exactly 24 fetches per frame; every write accepted outside fetch windows lands at its address with o_mem_we=1.
- p_scale=20, at line 19: a fetch of row 1 (addresses 32..63) is issued; line 20 displays row 1 and line 19 still shows row 0.
- Force an i_line 10 cycles after the previous one: o_underrun pulses for 1 cycle, or stays high with UNDERRUN_STICKY_EN.
- Assert i_rst mid-FETCH at k=5: o_mem_en=0 the next cycle, all outputs are 0, and normal fetching resumes on the next frame.
